// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size/sign encodings,
// the access FSM state type, fault cause codes and the fault classifier.
// No ports; imported by load_store_unit and lsu_align.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_ILLEGAL    = 2'b10,
        CAUSE_TIMEOUT    = 2'b11
    } err_cause_t;

    // Classifies an access at accept time. An unsupported funct3 wins over
    // alignment, since its size is undefined.
    function automatic err_cause_t check_access(input logic       is_store,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
        err_cause_t cause;
        cause = CAUSE_NONE;
        case (f3)
            F3_B:    cause = CAUSE_NONE;
            F3_H:    cause = off[0] ? CAUSE_MISALIGNED : CAUSE_NONE;
            F3_W:    cause = (off != 2'b00) ? CAUSE_MISALIGNED : CAUSE_NONE;
            F3_BU:   cause = is_store ? CAUSE_ILLEGAL : CAUSE_NONE;
            F3_HU:   cause = is_store ? CAUSE_ILLEGAL
                           : (off[0] ? CAUSE_MISALIGNED : CAUSE_NONE);
            default: cause = CAUSE_ILLEGAL;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3_i      : size/sign select (bits [1:0] size, bit 2 unsigned)
//   offset_i      : byte address bits [1:0]
//   store_data_i  : store data, low bytes significant
//   rdata_i       : read word returned by memory
//   be_o          : byte enables for a store
//   wdata_o       : store data replicated across all lanes of its size
//   load_data_o   : selected lane of rdata_i, sign/zero extended
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] lane;
    logic        sext;

    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        // Shift the addressed lane down to bit 0; only aligned sizes reach here.
        lane        = rdata_i >> {offset_i, 3'b000};
        sext        = ~funct3_i[2];
        case (funct3_i[1:0])
            2'b00: begin
                be_o        = 4'b0001 << offset_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{sext & lane[7]}}, lane[7:0]};
            end
            2'b01: begin
                be_o        = 4'b0011 << {offset_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{sext & lane[15]}}, lane[15:0]};
            end
            default: begin
                be_o        = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one access at a time from the pipeline,
// checks it for faults, drives a single-outstanding memory request and
// returns aligned/extended load data.
//   clk_i, reset_i                : clock, async active-low reset
//   req_valid_i, mem_read_i, mem_write_i, funct3_i, alu_result_i,
//   read_data2_i                  : access from the pipeline
//   stall_o, done_o, load_data_o,
//   err_o, err_cause_o            : status back to the pipeline
//   dmem_*                        : memory port (req held until gnt; rvalid
//                                   completes a load)
//   dbg_state_o                   : current FSM state
// Memory handshake: dmem_req_o and its address/we/be/wdata are held stable
// from the first request cycle until a cycle in which dmem_gnt_i is high;
// that cycle transfers the request. A load then completes on the first
// cycle with dmem_rvalid_i high; rvalid is ignored at all other times.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] read_data2_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output lsu_state_t  dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      load_data_q, load_data_d;
    err_cause_t       cause_q, cause_d;

    logic             accept;
    logic             timeout_hit;
    err_cause_t       fault;
    logic [2:0]       align_f3;
    logic [1:0]       align_off;
    logic [3:0]       align_be;
    logic [31:0]      align_wdata;
    logic [31:0]      align_load;

    assign accept      = (state_q == ST_IDLE) && req_valid_i && (mem_read_i || mem_write_i);
    // The counter has already recorded cnt_q waiting cycles; this one is the last allowed.
    assign timeout_hit = (cnt_q >= CNT_LAST);

    // In IDLE the aligner prepares store lanes from the incoming access;
    // afterwards it extracts load lanes using the captured size/offset.
    assign align_f3  = (state_q == ST_IDLE) ? funct3_i : funct3_q;
    assign align_off = (state_q == ST_IDLE) ? alu_result_i[1:0] : off_q;

    lsu_align u_align (
        .funct3_i     (align_f3),
        .offset_i     (align_off),
        .store_data_i (read_data2_i),
        .rdata_i      (dmem_rdata_i),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .load_data_o  (align_load)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        cause_d     = cause_q;
        fault       = check_access(mem_write_i, funct3_i, alu_result_i[1:0]);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    cause_d = fault;
                    if (fault != CAUSE_NONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_REQ;
                        we_d     = mem_write_i;
                        addr_d   = {alu_result_i[31:2], 2'b00};
                        be_d     = align_be;
                        wdata_d  = align_wdata;
                        funct3_d = funct3_i;
                        off_d    = alu_result_i[1:0];
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? ST_DONE : ST_RESP;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (dmem_rvalid_i) begin
                    state_d     = ST_DONE;
                    load_data_d = align_load;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            load_data_q <= '0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            cause_q     <= cause_d;
        end
    end

    assign stall_o      = accept || (state_q == ST_REQ) || (state_q == ST_RESP);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = (state_q == ST_DONE) && (cause_q != CAUSE_NONE);
    assign err_cause_o  = (state_q == ST_DONE) ? cause_q : 2'b00;
    assign load_data_o  = load_data_q;
    assign dmem_req_o   = (state_q == ST_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign dbg_state_o  = state_q;

endmodule
